// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointer and occupancy controller for a 16-entry FIFO; status is combinational from the pointers.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_ptr_ctrl #(
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic       rd_en,
   output logic       fifo_we,
   output logic       fifo_re,
   output logic [4:0] wptr,
   output logic [4:0] rptr,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       fifo_afull,
   output logic       fifo_aempty,
   output logic [4:0] fifo_cnt,
   output logic       fifo_ovf,
   output logic       fifo_udf
);

   localparam logic [4:0] LP_AF = 5'(AF_LEVEL);
   localparam logic [4:0] LP_AE = 5'(AE_LEVEL);

   logic [4:0] r_wptr;
   logic [4:0] r_rptr;
   logic [4:0] w_cnt;
   logic       w_full;
   logic       w_empty;
   logic       w_we;
   logic       w_re;

   // Wrap bit distinguishes full from empty when the slot bits match.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[4] != r_rptr[4]) && (r_wptr[3:0] == r_rptr[3:0]);
   assign w_cnt   = r_wptr - r_rptr;
   assign w_we    = wr_en & ~w_full;
   assign w_re    = rd_en & ~w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= 5'd0;
         r_rptr <= 5'd0;
      end else begin
         if (w_we) r_wptr <= r_wptr + 5'd1;
         if (w_re) r_rptr <= r_rptr + 5'd1;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic r_ovf;
   logic r_udf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (wr_en && w_full)  r_ovf <= 1'b1;
         if (rd_en && w_empty) r_udf <= 1'b1;
      end
   end

   assign fifo_ovf = r_ovf;
   assign fifo_udf = r_udf;
`else
   assign fifo_ovf = 1'b0;
   assign fifo_udf = 1'b0;
`endif

   assign fifo_we     = w_we;
   assign fifo_re     = w_re;
   assign wptr        = r_wptr;
   assign rptr        = r_rptr;
   assign fifo_full   = w_full;
   assign fifo_empty  = w_empty;
   assign fifo_cnt    = w_cnt;
   assign fifo_afull  = (w_cnt >= LP_AF);
   assign fifo_aempty = (w_cnt <= LP_AE);

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Randomized and directed bench for fifo_ptr_ctrl against an occupancy/transfer-count model.
// Error-flag expectations follow FIFO_ERR_FLAGS_EN.
module tb_fifo_ptr_ctrl;

   localparam int AF = 14;
   localparam int AE = 2;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       fifo_we, fifo_re, fifo_full, fifo_empty, fifo_afull, fifo_aempty;
   logic       fifo_ovf, fifo_udf;
   logic [4:0] wptr, rptr, fifo_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: occupancy plus total accepted writes/reads.
   int m_cnt  = 0;
   int m_wtot = 0;
   int m_rtot = 0;
   bit m_ovf  = 0;
   bit m_udf  = 0;

   fifo_ptr_ctrl #(.AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .fifo_we(fifo_we), .fifo_re(fifo_re), .wptr(wptr), .rptr(rptr),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_afull(fifo_afull), .fifo_aempty(fifo_aempty),
      .fifo_cnt(fifo_cnt), .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of requests, check outputs mid-cycle, then advance the model across the edge.
   task automatic step(input bit wr, input bit rd, input bit rs);
      bit we_e, re_e, ovf_e, udf_e;
      rst   = rs;
      wr_en = wr;
      rd_en = rd;
      @(negedge clk);
      we_e = wr && (m_cnt < DEPTH);
      re_e = rd && (m_cnt > 0);
`ifdef FIFO_ERR_FLAGS_EN
      ovf_e = m_ovf;
      udf_e = m_udf;
`else
      ovf_e = 1'b0;
      udf_e = 1'b0;
`endif
      check("fifo_we",     32'(fifo_we),     32'(we_e));
      check("fifo_re",     32'(fifo_re),     32'(re_e));
      check("wptr",        32'(wptr),        32'(m_wtot % 32));
      check("rptr",        32'(rptr),        32'(m_rtot % 32));
      check("fifo_cnt",    32'(fifo_cnt),    32'(m_cnt));
      check("fifo_full",   32'(fifo_full),   32'(m_cnt == DEPTH));
      check("fifo_empty",  32'(fifo_empty),  32'(m_cnt == 0));
      check("fifo_afull",  32'(fifo_afull),  32'(m_cnt >= AF));
      check("fifo_aempty", 32'(fifo_aempty), 32'(m_cnt <= AE));
      check("fifo_ovf",    32'(fifo_ovf),    32'(ovf_e));
      check("fifo_udf",    32'(fifo_udf),    32'(udf_e));
      if (rs) begin
         m_cnt = 0; m_wtot = 0; m_rtot = 0; m_ovf = 0; m_udf = 0;
      end else begin
         if (wr && m_cnt == DEPTH) m_ovf = 1;
         if (rd && m_cnt == 0)     m_udf = 1;
         m_cnt  = m_cnt + int'(we_e) - int'(re_e);
         m_wtot = m_wtot + int'(we_e);
         m_rtot = m_rtot + int'(re_e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Bring registers out of X before any comparison.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      step(0, 0, 0);                                  // reset state
      for (int i = 0; i < 16; i++) step(1, 0, 0);     // fill to 16
      step(1, 0, 0);                                  // overflow attempt from full
      step(1, 1, 0);                                  // full with both: read only
      step(1, 0, 0);                                  // back to full
      for (int i = 0; i < 16; i++) step(0, 1, 0);     // drain; ovf stays sticky
      step(0, 1, 0);                                  // underflow attempt
      step(1, 1, 0);                                  // empty with both: write only
      for (int i = 0; i < 2; i++) step(1, 0, 0);      // occupancy 3
      for (int i = 0; i < 40; i++) step(1, 1, 0);     // streaming across pointer rollover
      step(0, 0, 1);                                  // reset mid-operation
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      for (int i = 0; i < 2; i++) step(0, 1, 0);
      step(1, 1, 1);                                  // reset wins over requests
      step(0, 0, 0);

      // Random phases with shifting write/read bias to visit full, empty and everything between.
      for (int ph = 0; ph < 12; ph++) begin
         int wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
         int rp = 100 - wp;
         for (int i = 0; i < 150; i++) begin
            bit w = ($urandom_range(99) < wp);
            bit r = ($urandom_range(99) < rp);
            bit s = ($urandom_range(999) < 3);
            step(w, r, s);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
